// File: rtl/div.sv
// div: iterative 32-bit divider for the EX stage (DIV / DIVU).
//
// Restoring division, one trial subtraction per clock, fixed latency:
//   nonzero divisor -> ready_o high the cycle after the 34th edge from start
//   zero divisor    -> ready_o high the cycle after the 2nd edge, result 0
//
// Ports:
//   clk           clock, rising edge
//   rst           synchronous reset, active high
//   signed_div_i  1 = signed divide, 0 = unsigned
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       request, held high until the result is taken
//   annul_i       cancel the in-flight divide
//   result_o      {remainder, quotient}
//   ready_o       result valid
//
// Build option: define DIV_SIGNED_EN to compile in signed support. Without
// it, signed_div_i is ignored and every divide is unsigned.
//
// state       | meaning
// DIV_FREE    | idle, waiting for start_i
// DIV_BY_ZERO | divisor was zero, result forced to 0 next edge
// DIV_ON      | 32 shift/subtract steps in progress
// DIV_END     | result valid, waiting for start_i to drop

module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {
    DIV_FREE    = 2'd0,
    DIV_BY_ZERO = 2'd1,
    DIV_ON      = 2'd2,
    DIV_END     = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [5:0]  r_cnt;
  logic [32:0] r_rem;
  logic [31:0] r_dvd;
  logic [31:0] r_divisor;
  logic [63:0] r_result;

  logic        w_accept;
  logic        w_step;
  logic        w_finish;
  logic        w_zero_done;
  logic [31:0] w_op1_lat;
  logic [31:0] w_op2_lat;
  logic [32:0] w_rem_sh;
  logic [32:0] w_rem_diff;
  logic        w_fits;
  logic [31:0] w_quot;
  logic [31:0] w_remd;

`ifdef DIV_SIGNED_EN
  logic w_neg1;
  logic w_neg2;
  logic r_neg_q;
  logic r_neg_r;
  // rem[32] is always 0 after a step; it only exists to hold the shifted-out bit
  logic w_unused;

  assign w_unused  = r_rem[32];
  assign w_neg1    = signed_div_i & opdata1_i[31];
  assign w_neg2    = signed_div_i & opdata2_i[31];
  assign w_op1_lat = w_neg1 ? (~opdata1_i + 32'd1) : opdata1_i;
  assign w_op2_lat = w_neg2 ? (~opdata2_i + 32'd1) : opdata2_i;
  // 0x80000000 negates to itself, which gives the wrapping overflow result
  assign w_quot    = r_neg_q ? (~r_dvd + 32'd1) : r_dvd;
  assign w_remd    = r_neg_r ? (~r_rem[31:0] + 32'd1) : r_rem[31:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept) begin
      r_neg_q <= w_neg1 ^ w_neg2;
      r_neg_r <= w_neg1;
    end
  end
`else
  logic w_unused;

  assign w_unused  = ^{signed_div_i, r_rem[32]};
  assign w_op1_lat = opdata1_i;
  assign w_op2_lat = opdata2_i;
  assign w_quot    = r_dvd;
  assign w_remd    = r_rem[31:0];
`endif

  // one step: shift {rem, dvd} left, trial-subtract divisor from rem
  assign w_rem_sh   = {r_rem[31:0], r_dvd[31]};
  assign w_rem_diff = w_rem_sh - {1'b0, r_divisor};
  assign w_fits     = (w_rem_sh >= {1'b0, r_divisor});

  always_ff @(posedge clk) begin
    if (rst) r_state <= DIV_FREE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    w_zero_done = 1'b0;
    unique case (r_state)
      DIV_FREE: begin
        if (start_i && !annul_i) begin
          w_accept = 1'b1;
          if (opdata2_i == 32'd0) w_state_nxt = DIV_BY_ZERO;
          else                    w_state_nxt = DIV_ON;
        end
      end
      DIV_BY_ZERO: begin
        w_zero_done = 1'b1;
        w_state_nxt = DIV_END;
      end
      DIV_ON: begin
        if (annul_i || !start_i) begin
          w_state_nxt = DIV_FREE;
        end else if (r_cnt == 6'd32) begin
          w_finish    = 1'b1;
          w_state_nxt = DIV_END;
        end else begin
          w_step = 1'b1;
        end
      end
      DIV_END: begin
        if (!start_i) w_state_nxt = DIV_FREE;
      end
      default: w_state_nxt = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= 6'd0;
      r_rem     <= 33'd0;
      r_dvd     <= 32'd0;
      r_divisor <= 32'd0;
      r_result  <= 64'd0;
    end else begin
      if (w_accept) begin
        r_cnt     <= 6'd0;
        r_rem     <= 33'd0;
        r_dvd     <= w_op1_lat;
        r_divisor <= w_op2_lat;
      end else if (w_step) begin
        r_cnt <= r_cnt + 6'd1;
        r_rem <= w_fits ? w_rem_diff : w_rem_sh;
        r_dvd <= {r_dvd[30:0], w_fits};
      end
      if (w_finish)    r_result <= {w_remd, w_quot};
      if (w_zero_done) r_result <= 64'd0;
    end
  end

  assign result_o = r_result;
  assign ready_o  = (r_state == DIV_END);

endmodule

// File: tb/tb_div.sv
// tb_div: directed-vector bench for div (latency, handshake, annul, reset).
module tb_div;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int checks = 0;
  int errors = 0;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full handshake from a negedge: lat = edges until the result edge
  // (33 for nonzero divisor, 1 for zero). Operands are scrambled after E0.
  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [63:0] exp, input int lat);
    opdata1_i    = a;
    opdata2_i    = b;
    signed_div_i = s;
    start_i      = 1'b1;
    annul_i      = 1'b0;
    @(negedge clk);
    opdata1_i    = ~a;
    opdata2_i    = b ^ 32'h5A5A_0001;
    signed_div_i = ~s;
    repeat (lat - 1) @(negedge clk);
    chk1({tag, " ready low before result edge"}, ready_o, 1'b0);
    @(negedge clk);
    chk1({tag, " ready"}, ready_o, 1'b1);
    chk64({tag, " result"}, result_o, exp);
    @(negedge clk);
    chk1({tag, " ready held"}, ready_o, 1'b1);
    start_i = 1'b0;
    @(negedge clk);
    chk1({tag, " ready drop"}, ready_o, 1'b0);
    chk64({tag, " result hold"}, result_o, exp);
  endtask

  initial begin
    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    repeat (2) @(negedge clk);
    chk1("reset ready", ready_o, 1'b0);
    chk64("reset result", result_o, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    do_div("u 100/7", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33);
    do_div("u 7/100", 32'd7, 32'd100, 1'b0, 64'h00000007_00000000, 33);
    do_div("u max/max", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'h00000000_00000001, 33);
    do_div("div0", 32'd1234, 32'd0, 1'b0, 64'h0, 1);

    // annul at E10
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i   = 1'b1;
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    chk1("annul ready", ready_o, 1'b0);
    repeat (35) @(negedge clk);
    chk1("annul ready later", ready_o, 1'b0);
    chk64("annul result kept", result_o, 64'h0);

    // annul in DIV_FREE blocks acceptance for that edge
    opdata1_i = 32'hFFFFFFFF;
    opdata2_i = 32'd1;
    start_i   = 1'b1;
    annul_i   = 1'b1;
    @(negedge clk);
    chk1("annul blocks start", ready_o, 1'b0);
    do_div("u ffffffff/1", 32'hFFFFFFFF, 32'd1, 1'b0, 64'h00000000_FFFFFFFF, 33);

    // start dropped mid-op discards the partial result
    opdata1_i = 32'd50;
    opdata2_i = 32'd3;
    start_i   = 1'b1;
    repeat (5) @(negedge clk);
    start_i = 1'b0;
    repeat (40) @(negedge clk);
    chk1("start drop ready", ready_o, 1'b0);
    chk64("start drop result", result_o, 64'h00000000_FFFFFFFF);

    // reset at E20
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i   = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk1("midop reset ready", ready_o, 1'b0);
    chk64("midop reset result", result_o, 64'h0);
    rst     = 1'b0;
    start_i = 1'b0;
    @(negedge clk);
    do_div("u 100/7 after reset", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33);

`ifdef DIV_SIGNED_EN
    do_div("s -7/2", 32'hFFFFFFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 33);
    do_div("s ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, 33);
    do_div("s 7/-2", 32'd7, 32'hFFFFFFFE, 1'b1, 64'h00000001_FFFFFFFD, 33);
    do_div("u fff9/2", 32'hFFFFFFF9, 32'd2, 1'b0, 64'h00000001_7FFFFFFC, 33);
`else
    do_div("nosign fff9/2", 32'hFFFFFFF9, 32'd2, 1'b1, 64'h00000001_7FFFFFFC, 33);
    do_div("nosign ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h80000000_00000000, 33);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 The block SHALL expose the following ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- signed_div_i  in  1  1 = signed divide (DIV), 0 = unsigned (DIVU).
- opdata1_i  in  32  dividend.
- opdata2_i  in  32  divisor.
- start_i  in  1  request from the EX stage; held high until the result is taken.
- annul_i  in  1  cancel the in-flight divide (pipeline flush).
- result_o  out  64  {remainder[31:0], quotient[31:0]}, feeding HI and LO respectively.
- ready_o  out  1  result valid.

REQ-002 The block SHALL define four states: DIV_FREE, DIV_BY_ZERO, DIV_ON and DIV_END.

Function
REQ-003 In DIV_FREE with start_i=1 and annul_i=0, the block SHALL latch both operands and signed_div_i at the same edge (E0).
- If opdata2_i==0, next state is DIV_BY_ZERO.
- Otherwise, next state is DIV_ON with cnt=0.

REQ-004 When signed_div_i=1, a negative operand SHALL be replaced by its two's complement at latch time; unsigned operands SHALL be latched unchanged.

REQ-005 DIV_ON SHALL perform one restoring trial-subtraction step per edge on a 65-bit working register {rem[32:0], dvd[31:0]}, for exactly 32 steps (E1..E32, cnt 0->32).

REQ-006 Each step SHALL do the following:
- shift {rem, dvd} left by 1 (dvd[31] enters rem[0]);
- if rem >= divisor, rem becomes rem - divisor and the shifted-in quotient bit dvd[0] becomes 1;
- otherwise dvd[0] becomes 0.

REQ-007 At edge E33 (DIV_ON with cnt==32), the block SHALL register result_o and move to DIV_END.
- Unsigned: result_o = {rem[31:0], dvd}.
- Signed: the quotient is negated when the original operand signs differ, and the remainder is negated when the original dividend was negative.

REQ-008 DIV_BY_ZERO SHALL move to DIV_END on the next edge with result_o = 64'h0.

REQ-009 In DIV_END, ready_o SHALL be 1.
- The block stays in DIV_END while start_i=1.
- On the first edge with start_i=0 it returns to DIV_FREE, and ready_o is 0 from that edge on.

REQ-010 ready_o SHALL be 0 in every state other than DIV_END.

REQ-011 result_o SHALL hold its last registered value until the next result is registered or reset is applied.

REQ-012 In DIV_ON, if annul_i=1 or start_i=0 at any edge, the block SHALL return to DIV_FREE without asserting ready_o, and the partial result SHALL be discarded.

REQ-013 annul_i=1 in DIV_FREE SHALL block acceptance of start_i on that edge.

REQ-014 Latency SHALL be fixed, independent of operand values.
- Nonzero divisor: ready_o first high in the cycle after E33.
- Zero divisor: ready_o first high in the cycle after E1.

REQ-015 Signed overflow SHALL wrap with no exception: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0.

REQ-016 The block SHALL not sample opdata1_i, opdata2_i or signed_div_i after E0.

Reset
REQ-017 With rst=1 at a rising edge, the block SHALL:
- enter DIV_FREE;
- drive ready_o=0 and result_o=64'h0;
- clear cnt and the working register.

REQ-018 Reset SHALL take priority over start_i and annul_i, including when a divide is in progress.

REQ-019 After reset, the first accepted start_i SHALL produce a correct result with no residue from the aborted operation.

Configuration
REQ-020 The feature macro SHALL be DIV_SIGNED_EN.
- Defined: signed operation per REQ-004 and REQ-007, selected by signed_div_i.
- Not defined: signed_div_i is ignored, every divide is unsigned, and the sign pre- and post-correction logic is not compiled in.
- Latency and handshake SHALL be identical in both builds.

Verification
REQ-021 Unsigned: opdata1=100, opdata2=7, signed=0, start held -> ready_o after E33, result_o=64'h00000002_0000000E; drop start -> ready_o=0 next edge.

REQ-022 Signed (DIV_SIGNED_EN defined): -7 / 2 -> result_o=64'hFFFFFFFF_FFFFFFFD; 0x80000000 / 0xFFFFFFFF -> 64'h00000000_80000000.

REQ-023 Divide by zero: opdata2=0, start held -> ready_o after E1, result_o=0.

REQ-024 Annul: annul_i pulsed at E10 of a divide -> ready_o stays 0 and the block is in DIV_FREE; next divide 0xFFFFFFFF / 1 -> result_o=64'h00000000_FFFFFFFF.

REQ-025 Reset mid-op: rst at E20 -> ready_o=0, result_o=0; subsequent 100 / 7 -> REQ-021 response.

REQ-026 Unsigned build (DIV_SIGNED_EN not defined): signed_div_i=1, 0xFFFFFFF9 / 2 -> result_o=64'h00000001_7FFFFFFC.
